heston_payoff_accum: RTL and testbench

Monte Carlo payoff accumulator sitting directly downstream of `exp_taylor_q824` in the Heston pricer. It consumes one terminal growth factor exp(ln(S_T/S0)) per simulated path, in Q8.24, and scales it by S0. It then forms the European call payoff max(S_T − K, 0), accumulates over 2^LOG2_PATHS paths, and produces the discounted mean as the option price in Q8.24.

---
 rtl/heston_payoff_accum_if.sv | 19 +
 rtl/heston_payoff_accum.sv | 129 ++++++++++++
 tb/tb_heston_payoff_accum.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/heston_payoff_accum_if.sv
// Path-sample stream from exp_taylor_q824 into the payoff accumulator.
// Source drives the growth factor, sink answers with in_ready.
interface heston_payoff_accum_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] exp_q824;

  modport master (
    output in_valid,
    output exp_q824,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  exp_q824,
    output in_ready
  );
endinterface

// File: rtl/heston_payoff_accum.sv
// Heston MC payoff accumulator: S0*exp -> call payoff -> sum over
// 2^LOG2_PATHS paths -> discounted mean price in Q8.24.
module heston_payoff_accum #(
  parameter int LOG2_PATHS = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] s0_q824,
  input  logic [31:0] strike_q824,
  input  logic [31:0] disc_q824,
  heston_payoff_accum_if.slave smp,
  output logic        busy,
  output logic        done,
  output logic [31:0] price_q824
);

  localparam int N  = 1 << LOG2_PATHS;
  localparam int CW = LOG2_PATHS + 1;
  localparam int AW = 32 + LOG2_PATHS;
  localparam logic [CW-1:0] NCNT = CW'(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  localparam logic [31:0] SAT32 = 32'h7FFF_FFFF;
  localparam logic [63:0] SAT64 = 64'h007F_FFFF_FFFF_FFFF;

  typedef enum logic [2:0] {
    IDLE, RUN, DRAIN, SCALE, DONE
  } state_t;

  state_t state, nstate;

  logic [31:0]   s0_r, k_r, disc_r;
  logic [CW-1:0] acnt, rcnt, rnext;
  logic [AW-1:0] acc;
  logic          s1_v, s2_v;
  logic [31:0]   prod, payoff;

  logic          start_ok, xfer;
  logic [31:0]   s0p, ep, dp, mean;
  logic [63:0]   mul1, mul2;
  logic [32:0]   diff;
  logic [31:0]   prod_c, pay_c, price_c;

  assign start_ok = start && (state == IDLE || state == DONE);
  assign xfer     = smp.in_valid && smp.in_ready;
  assign rnext    = rcnt + CW'(s2_v);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:  if (start) nstate = RUN;
      DONE:  if (start) nstate = RUN;
      RUN:   if (xfer && acnt == LAST) nstate = DRAIN;
      DRAIN: if (rnext == NCNT) nstate = SCALE;
      SCALE: nstate = DONE;
      default: nstate = IDLE;
    endcase
  end

  always_comb begin
    smp.in_ready = (state == RUN);
    busy = (state == RUN) || (state == DRAIN) || (state == SCALE);
    done = (state == DONE);
  end

  // Negative operands clamp to zero before the unsigned multiplies.
  always_comb begin
    s0p  = s0_r[31] ? 32'd0 : s0_r;
    ep   = smp.exp_q824[31] ? 32'd0 : smp.exp_q824;
    mul1 = {32'd0, s0p} * {32'd0, ep};
    prod_c = (mul1 > SAT64) ? SAT32 : mul1[55:24];
  end

  always_comb begin
    diff  = {1'b0, prod} - {k_r[31], k_r};
    pay_c = 32'd0;
    if ($signed(prod) > $signed(k_r))
      pay_c = (diff > {1'b0, SAT32}) ? SAT32 : diff[31:0];
  end

  always_comb begin
    mean    = acc[AW-1:LOG2_PATHS];
    dp      = disc_r[31] ? 32'd0 : disc_r;
    mul2    = {32'd0, mean} * {32'd0, dp};
    price_c = (mul2 > SAT64) ? SAT32 : mul2[55:24];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_r       <= '0;
      k_r        <= '0;
      disc_r     <= '0;
      acnt       <= '0;
      rcnt       <= '0;
      acc        <= '0;
      s1_v       <= 1'b0;
      s2_v       <= 1'b0;
      prod       <= '0;
      payoff     <= '0;
      price_q824 <= '0;
    end else begin
      s1_v <= xfer;
      s2_v <= s1_v;
      if (xfer) prod <= prod_c;
      if (s1_v) payoff <= pay_c;
      if (start_ok) begin
        s0_r   <= s0_q824;
        k_r    <= strike_q824;
        disc_r <= disc_q824;
        acnt   <= '0;
        rcnt   <= '0;
        acc    <= '0;
      end else begin
        if (xfer) acnt <= acnt + 1'b1;
        if (s2_v) begin
          acc  <= acc + AW'(payoff);
          rcnt <= rnext;
        end
      end
      if (state == SCALE) price_q824 <= price_c;
    end
  end

endmodule

// File: tb/tb_heston_payoff_accum.sv
// Randomised and directed bench for heston_payoff_accum, LOG2_PATHS=2,
// scored against an arithmetic model of the payoff/mean/discount rules.
module tb_heston_payoff_accum;

  localparam int L = 2;
  localparam int NP = 1 << L;
  localparam longint MAXP = 64'h7FFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] s0, kk, disc;
  logic        busy, done;
  logic [31:0] price;
  logic [31:0] smp [NP];

  int n_chk = 0;
  int n_fail = 0;

  heston_payoff_accum_if bus ();

  heston_payoff_accum #(.LOG2_PATHS(L)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .s0_q824     (s0),
    .strike_q824 (kk),
    .disc_q824   (disc),
    .smp         (bus.slave),
    .busy        (busy),
    .done        (done),
    .price_q824  (price)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic longint clamp0(input logic [31:0] v);
    int s;
    s = $signed(v);
    return (s < 0) ? 64'd0 : longint'(s);
  endfunction

  function automatic logic [31:0] model(input logic [31:0] s0v,
                                        input logic [31:0] kv,
                                        input logic [31:0] dv);
    longint sum, p, pay, kl, mean, r;
    int ki;
    sum = 0;
    ki = $signed(kv);
    kl = longint'(ki);
    for (int i = 0; i < NP; i++) begin
      p = (clamp0(s0v) * clamp0(smp[i])) >>> 24;
      if (p > MAXP) p = MAXP;
      pay = (p > kl) ? p - kl : 0;
      if (pay > MAXP) pay = MAXP;
      sum += pay;
    end
    mean = sum / NP;
    r = (mean * clamp0(dv)) >>> 24;
    if (r > MAXP) r = MAXP;
    return r[31:0];
  endfunction

  task automatic run(input logic [31:0] s0v, input logic [31:0] kv,
                     input logic [31:0] dv, input bit gaps,
                     input bit midstart, input logic [31:0] expv,
                     input string tag);
    int idx, cyc, lat, rdy_hi;
    bit x;
    @(posedge clk); #1;
    chk({tag, "_rdy_pre"}, 32'(bus.in_ready), 32'd0);
    start = 1'b1;
    s0 = s0v;
    kk = kv;
    disc = dv;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    s0 = $urandom;
    kk = $urandom;
    disc = $urandom;
    chk({tag, "_done_clr"}, 32'(done), 32'd0);
    idx = 0;
    cyc = 0;
    while (idx < NP && cyc < 100) begin
      bus.in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      bus.exp_q824 = smp[idx];
      start = midstart && (idx == 2);
      @(negedge clk);
      x = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      start = 1'b0;
      if (x) idx++;
      cyc++;
    end
    chk({tag, "_xfers"}, 32'(idx), 32'(NP));
    bus.in_valid = 1'b1;
    bus.exp_q824 = 32'h7FFF_FFFF;
    lat = 0;
    rdy_hi = 0;
    while (lat < 20) begin
      @(negedge clk);
      if (bus.in_ready) rdy_hi++;
      if (done) break;
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'd3);
    chk({tag, "_rdy_post"}, 32'(rdy_hi), 32'd0);
    chk({tag, "_price"}, price, expv);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] rs, rk, rd, re;
    rst_n = 1'b0;
    start = 1'b0;
    s0 = '0;
    kk = '0;
    disc = '0;
    bus.in_valid = 1'b0;
    bus.exp_q824 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdy", 32'(bus.in_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_price", price, 32'd0);
    rst_n = 1'b1;

    smp = '{32'h0200_0000, 32'h0180_0000, 32'h0080_0000, 32'h0100_0000};
    run(32'h0100_0000, 32'h0100_0000, 32'h0100_0000, 0, 0,
        32'h0060_0000, "t1");
    run(32'h0100_0000, 32'h0100_0000, 32'h0080_0000, 1, 0,
        32'h0030_0000, "t2");

    smp = '{32'h0200_0000, 32'h0200_0000, 32'h0200_0000, 32'h0200_0000};
    run(32'h6400_0000, 32'h0, 32'h0100_0000, 0, 0, 32'h7FFF_FFFF, "sat");

    smp = '{32'hFF00_0000, 32'hFF00_0000, 32'hFF00_0000, 32'hFF00_0000};
    run(32'h0100_0000, 32'h0, 32'h0100_0000, 0, 0, 32'h0, "negexp");

    smp = '{32'h00FF_FFFF, 32'h0080_0000, 32'h0000_0001, 32'h00C0_0000};
    run(32'h0300_0000, 32'h0300_0000, 32'h0100_0000, 1, 0, 32'h0, "otm");

    smp = '{32'h0200_0000, 32'h0180_0000, 32'h0080_0000, 32'h0100_0000};
    run(32'h0100_0000, 32'h0100_0000, 32'h0100_0000, 0, 1,
        32'h0060_0000, "midst");

    @(posedge clk); #1;
    start = 1'b1;
    s0 = 32'h0100_0000;
    kk = 32'h0;
    disc = 32'h0100_0000;
    @(posedge clk); #1;
    start = 1'b0;
    bus.in_valid = 1'b1;
    bus.exp_q824 = 32'h0400_0000;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_rdy", 32'(bus.in_ready), 32'd0);
    chk("abort_price", price, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    run(32'h0100_0000, 32'h0100_0000, 32'h0100_0000, 0, 0,
        32'h0060_0000, "post_rst");
    run(32'h0200_0000, 32'h0100_0000, 32'h0100_0000, 0, 0,
        32'h0180_0000, "second");

    for (int t = 0; t < 8; t++) begin
      rs = $urandom_range(0, 32'h0800_0000);
      if (t == 3) rs = 32'hF000_0000;
      rk = $urandom_range(0, 32'h0600_0000);
      if (t == 5) rk = 32'hC000_0000;
      rd = $urandom_range(0, 32'h0110_0000);
      if (t == 6) rd = 32'h8000_0000;
      for (int i = 0; i < NP; i++) begin
        re = $urandom_range(0, 32'h0400_0000);
        if ($urandom_range(0, 5) == 0) re = $urandom | 32'h8000_0000;
        smp[i] = re;
      end
      run(rs, rk, rd, 1, (t == 2), model(rs, rk, rd), $sformatf("rnd%0d", t));
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
